// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 receiver with 16x oversampling,
// 3-sample majority vote and a show-ahead receive FIFO.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   rx_done,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  logic          rx_m;
  logic          rxs;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state;
  state_t        state_n;
  logic [3:0]    scnt;
  logic [2:0]    bcnt;
  logic [2:0]    smp;
  logic [7:0]    shreg;
  logic          vote_end;
  logic          vote_mid;
  logic          push_req;
  logic          ferr_req;
  logic          do_push;
  logic          do_pop;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // two-flop synchronizer, idle-high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rxs, rx_m} <= 2'b11;
    else      {rxs, rx_m} <= {rx_m, rx};
  end

  // free-running 16x baud tick, never re-aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  // smp holds samples 7,8,9 at window end;
  // mid-window vote uses live rxs as the 9th
  assign vote_end = (smp[2] & smp[1]) |
                    (smp[2] & smp[0]) |
                    (smp[1] & smp[0]);
  assign vote_mid = (smp[1] & smp[0]) |
                    (smp[1] & rxs) |
                    (smp[0] & rxs);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // next state and frame-level events
  always_comb begin
    state_n  = state;
    push_req = 1'b0;
    ferr_req = 1'b0;
    unique case (state)
      IDLE:  if (!rxs) state_n = START;
      START: if (tick && scnt == 4'd15)
               state_n = vote_end ? IDLE : DATA;
      DATA:  if (tick && scnt == 4'd15 && bcnt == 3'd7)
               state_n = STOP;
      STOP:  if (tick && scnt == 4'd9) begin
               if (vote_mid) begin
                 push_req = 1'b1;
                 state_n  = IDLE;
               end else begin
                 ferr_req = 1'b1;
                 state_n  = BRK;
               end
             end
      BRK:   if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // bit window counters, samples, shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt  <= '0;
      bcnt  <= '0;
      smp   <= '0;
      shreg <= '0;
    end else if (state == IDLE) begin
      scnt <= '0;
      bcnt <= '0;
    end else if (tick) begin
      scnt <= scnt + 1'b1;
      if (scnt >= 4'd7 && scnt <= 4'd9)
        smp <= {smp[1:0], rxs};
      if (state == DATA && scnt == 4'd15) begin
        shreg <= {vote_end, shreg[7:1]};
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

  assign do_pop  = rd_en && !empty;
  assign do_push = push_req && (!full || do_pop);

  // FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (do_push && !do_pop): count <= count + 1'b1;
        (do_pop && !do_push): count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // one-cycle event pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= do_push;
      overrun   <= push_req && !do_push;
      frame_err <= ferr_req;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table, corner sequences
// and random frames against a queue model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DEPTH    = 8;
  localparam int BT       = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int cyc = 0;
  int d0, f0, o0;

  always @(negedge clk) begin
    n_done <= n_done + int'(rx_done);
    n_ferr <= n_ferr + int'(frame_err);
    n_ovr  <= n_ovr + int'(overrun);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic [7:0] d;
    int         done;
    int         ovr;
    int         cnt;
    logic       full;
  } vec_t;

  vec_t tv [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic wclk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic snap();
    d0 = n_done;
    f0 = n_ferr;
    o0 = n_ovr;
  endtask

  task automatic chk_ev(input string nm,
                        input int ed, input int ef,
                        input int eo);
    chk({nm, "_done"}, n_done - d0, ed);
    chk({nm, "_ferr"}, n_ferr - f0, ef);
    chk({nm, "_ovr"}, n_ovr - o0, eo);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input int extra,
                            input int gb);
    logic v;
    for (int s = 0; s < 10; s++) begin
      v = (s == 0) ? 1'b0 : (s == 9) ? stop : d[s-1];
      rx = v;
      if (gb >= 0 && s == gb + 1) begin
        wclk(80);
        rx = ~v;
        wclk(10);
        rx = v;
        wclk(70);
      end else begin
        wclk(BT);
      end
    end
    if (!stop) begin
      wclk(extra * BT);
      rx = 1'b1;
    end
  endtask

  task automatic drain(input string nm,
                       input int first, input int n);
    for (int k = 0; k < n; k++) begin
      chk(nm, rd_data, 32'((first + k) & 8'hff));
      rd_en = 1'b1;
      wclk(1);
      rd_en = 1'b0;
    end
    chk({nm, "_empty"}, empty, 1);
    chk({nm, "_zero"}, rd_data, 0);
  endtask

  logic [7:0] q [$];
  logic [7:0] rb;
  int         p, first, dedge, g, pops;
  logic       bad;

  initial begin
    for (int i = 0; i < 9; i++) begin
      tv[i].d    = 8'(i);
      tv[i].done = (i < 8) ? 1 : 0;
      tv[i].ovr  = (i == 8) ? 1 : 0;
      tv[i].cnt  = (i < 8) ? i + 1 : 8;
      tv[i].full = (i >= 7);
    end

    wclk(3);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_pulses", {rx_done, frame_err, overrun}, 0);
    wclk(2);
    rst = 1'b1;
    wclk(5);

    // pop on empty
    rd_en = 1'b1;
    wclk(1);
    rd_en = 1'b0;
    chk("pop_empty_count", count, 0);
    chk("pop_empty_empty", empty, 1);

    // back-to-back normal frames
    snap();
    send_frame(8'h55, 1'b1, 0, -1);
    send_frame(8'hA3, 1'b1, 0, -1);
    wclk(2);
    chk_ev("norm", 2, 0, 0);
    chk("norm_count", count, 2);
    chk("norm_head", rd_data, 8'h55);
    rd_en = 1'b1;
    wclk(1);
    rd_en = 1'b0;
    chk("norm_pop1", rd_data, 8'hA3);
    rd_en = 1'b1;
    wclk(1);
    rd_en = 1'b0;
    chk("norm_pop2_empty", empty, 1);
    chk("norm_pop2_data", rd_data, 0);

    // false start
    snap();
    rx = 1'b0;
    wclk(30);
    rx = 1'b1;
    wclk(300);
    chk_ev("noise", 0, 0, 0);
    chk("noise_count", count, 0);

    // glitch inside bit 2
    snap();
    send_frame(8'h0F, 1'b1, 0, 2);
    wclk(2);
    chk_ev("glitch", 1, 0, 0);
    chk("glitch_data", rd_data, 8'h0F);
    drain("glitch_drain", 8'h0F, 1);

    // framing error with held-low line
    snap();
    send_frame(8'h3C, 1'b0, 2, -1);
    wclk(BT);
    chk_ev("ferr", 0, 1, 0);
    chk("ferr_count", count, 0);
    snap();
    send_frame(8'h81, 1'b1, 0, -1);
    wclk(2);
    chk_ev("after_ferr", 1, 0, 0);
    drain("after_ferr_data", 8'h81, 1);

    // overrun table
    for (int i = 0; i < 9; i++) begin
      snap();
      send_frame(tv[i].d, 1'b1, 0, -1);
      wclk(2);
      chk_ev($sformatf("ovr%0d", i),
             tv[i].done, 0, tv[i].ovr);
      chk($sformatf("ovr%0d_count", i), count, tv[i].cnt);
      chk($sformatf("ovr%0d_full", i), full, tv[i].full);
    end
    drain("ovr_drain", 0, 8);

    // full FIFO, pop in the push cycle
    for (int i = 0; i < 8; i++)
      send_frame(8'(i), 1'b1, 0, -1);
    wclk(2);
    chk("fp_pre_full", full, 1);
    snap();
    p     = cyc;
    first = ((p + 4 + 9) / 10) * 10;
    dedge = first + 153 * 10;
    g     = 0;
    fork
      send_frame(8'h08, 1'b1, 0, -1);
      begin
        while (cyc < dedge - 1 && g < 5000) begin
          wclk(1);
          g++;
        end
        rd_en = 1'b1;
        wclk(1);
        rd_en = 1'b0;
      end
    join
    if (g >= 5000) begin
      tests++;
      fails++;
      $display("FAIL fp_align: waited %0d cycles, limit 5000", g);
    end
    wclk(2);
    chk_ev("fp", 1, 0, 0);
    chk("fp_count", count, 8);
    drain("fp_drain", 1, 8);

    // reset in the middle of a frame
    send_frame(8'h42, 1'b1, 0, -1);
    wclk(2);
    chk("mid_pre_count", count, 1);
    rb = 8'h99;
    rx = 1'b0;
    wclk(BT);
    for (int b = 0; b < 4; b++) begin
      rx = rb[b];
      wclk(BT);
    end
    rx = rb[4];
    wclk(80);
    rst = 1'b0;
    rx = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    wclk(4);
    rst = 1'b1;
    snap();
    wclk(2 * BT);
    chk_ev("mid", 0, 0, 0);
    chk("mid_count", count, 0);
    chk("mid_full", full, 0);
    chk("mid_rd_data", rd_data, 0);
    send_frame(8'hF0, 1'b1, 0, -1);
    wclk(2);
    chk("mid_next_data", rd_data, 8'hF0);
    chk("mid_next_count", count, 1);

    // random frames against a queue model
    q.delete();
    q.push_back(8'hF0);
    for (int i = 0; i < 16; i++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      snap();
      send_frame(rb, !bad, 1, -1);
      wclk(4);
      if (bad) begin
        chk_ev("rnd_bad", 0, 1, 0);
      end else if (q.size() < DEPTH) begin
        q.push_back(rb);
        chk_ev("rnd_push", 1, 0, 0);
      end else begin
        chk_ev("rnd_full", 0, 0, 1);
      end
      chk("rnd_count", count, q.size());
      pops = (i < 8) ? 0 : $urandom_range(0, 2);
      for (int k = 0; k < pops; k++) begin
        if (q.size() > 0) begin
          chk("rnd_pop", rd_data, q.pop_front());
        end else begin
          chk("rnd_pop_empty", empty, 1);
        end
        rd_en = 1'b1;
        wclk(1);
        rd_en = 1'b0;
      end
      wclk($urandom_range(0, 40));
    end
    while (q.size() > 0) begin
      chk("rnd_drain", rd_data, q.pop_front());
      rd_en = 1'b1;
      wclk(1);
      rd_en = 1'b0;
    end
    chk("rnd_end_empty", empty, 1);
    chk("rnd_end_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
